seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 87 ++++++++
 tb/tb_seq_restoring_divider.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential radix-2 restoring divider, 2N-bit dividend by N-bit divisor
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operand handshake (u: 2N-bit dividend, v: N-bit divisor)
//   out_valid, out_ready result handshake (q: quotient, rem: remainder, err: div-by-zero/overflow)
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] u,
    input  logic [N-1:0]   v,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   q,
    output logic [N-1:0]   rem,
    output logic           err
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [N:0]    p, p_sh, p_n;
    logic [N-1:0]  qr, q_n, d;
    logic [CW-1:0] cnt;
    logic          fits;
    always_comb begin
        state_n   = state;
        p_sh      = {p[N-1:0], qr[N-1]};
        fits      = p_sh >= {1'b0, d};
        p_n       = fits ? p_sh - {1'b0, d} : p_sh;
        q_n       = {qr[N-2:0], fits};
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        case (state)
            IDLE:    state_n = in_valid ? RUN : IDLE;
            // error results are loaded at accept and pass through RUN for one edge
            RUN:     state_n = (err || cnt == CW'(N - 1)) ? DONE : RUN;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            qr    <= '0;
            d     <= '0;
            cnt   <= '0;
            q     <= '0;
            rem   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (in_valid) begin
                    if (v == '0) begin
                        err <= 1'b1;
                        q   <= '1;
                        rem <= u[N-1:0];
                    end else if (u[2*N-1:N] >= v) begin
                        err <= 1'b1;
                        q   <= '1;
                        rem <= '0;
                    end else begin
                        err <= 1'b0;
                        p   <= {1'b0, u[2*N-1:N]};
                        qr  <= u[N-1:0];
                        d   <= v;
                        cnt <= '0;
                    end
                end
                RUN: if (!err) begin
                    p   <= p_n;
                    qr  <= q_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        q   <= q_n;
                        rem <= p_n[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed self-checking bench for seq_restoring_divider (N = 8)
module tb_seq_restoring_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] u = '0;
    logic [7:0]  v = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  q, rem;
    logic        err;
    int checks = 0;
    int failures = 0;

    seq_restoring_divider #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .u(u), .v(v),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .rem(rem), .err(err)
    );

    always #5 clk = ~clk;

    // drives one accept edge, returns edges until out_valid (0 = right after accept, -1 = timeout)
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        u = a;
        v = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        if (out_valid) lat = 0;
        else for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
        if (q !== 8'd0) begin failures++; $display("FAIL reset_q got=%0d want=0", q); end
        if (rem !== 8'd0) begin failures++; $display("FAIL reset_rem got=%0d want=0", rem); end
    endtask

    task automatic test_round_trip();
        int lat;
        do_op(16'd7400, 8'd37, lat);
        checks += 5;
        if (lat !== 8) begin failures++; $display("FAIL rt_latency got=%0d want=8", lat); end
        if (q !== 8'd200) begin failures++; $display("FAIL rt_q got=%0d want=200", q); end
        if (rem !== 8'd0) begin failures++; $display("FAIL rt_rem got=%0d want=0", rem); end
        if (err !== 1'b0) begin failures++; $display("FAIL rt_err got=%b want=0", err); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rt_in_ready got=%b want=0", in_ready); end
        release_result();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rt_release_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rt_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_max_quotient();
        int lat;
        do_op(16'd65279, 8'd255, lat);
        checks += 4;
        if (lat !== 8) begin failures++; $display("FAIL maxq_latency got=%0d want=8", lat); end
        if (q !== 8'd255) begin failures++; $display("FAIL maxq_q got=%0d want=255", q); end
        if (rem !== 8'd254) begin failures++; $display("FAIL maxq_rem got=%0d want=254", rem); end
        if (err !== 1'b0) begin failures++; $display("FAIL maxq_err got=%b want=0", err); end
        release_result();
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(16'd1234, 8'd0, lat);
        checks += 4;
        if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d want=1", lat); end
        if (q !== 8'd255) begin failures++; $display("FAIL dz_q got=%0d want=255", q); end
        if (rem !== 8'd210) begin failures++; $display("FAIL dz_rem got=%0d want=210", rem); end
        if (err !== 1'b1) begin failures++; $display("FAIL dz_err got=%b want=1", err); end
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        do_op(16'd65535, 8'd255, lat);
        checks += 4;
        if (lat !== 1) begin failures++; $display("FAIL ovf_latency got=%0d want=1", lat); end
        if (q !== 8'd255) begin failures++; $display("FAIL ovf_q got=%0d want=255", q); end
        if (rem !== 8'd0) begin failures++; $display("FAIL ovf_rem got=%0d want=0", rem); end
        if (err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b want=1", err); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(16'd7400, 8'd37, lat);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL bp_latency got=%0d want=8", lat); end
        u = 16'd100;
        v = 8'd7;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks += 5;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", c, out_valid); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready c=%0d got=%b want=0", c, in_ready); end
            if (q !== 8'd200) begin failures++; $display("FAIL bp_hold_q c=%0d got=%0d want=200", c, q); end
            if (rem !== 8'd0) begin failures++; $display("FAIL bp_hold_rem c=%0d got=%0d want=0", c, rem); end
            if (err !== 1'b0) begin failures++; $display("FAIL bp_hold_err c=%0d got=%b want=0", c, err); end
        end
        in_valid = 1'b0;
        release_result();
        checks += 2;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_idle_valid got=%b want=0", out_valid); end
        do_op(16'd100, 8'd7, lat);
        checks += 4;
        if (lat !== 8) begin failures++; $display("FAIL bp2_latency got=%0d want=8", lat); end
        if (q !== 8'd14) begin failures++; $display("FAIL bp2_q got=%0d want=14", q); end
        if (rem !== 8'd2) begin failures++; $display("FAIL bp2_rem got=%0d want=2", rem); end
        if (err !== 1'b0) begin failures++; $display("FAIL bp2_err got=%b want=0", err); end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        u = 16'd7400;
        v = 8'd37;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rmr_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rmr_out_valid got=%b want=0", out_valid); end
        if (q !== 8'd0) begin failures++; $display("FAIL rmr_q got=%0d want=0", q); end
        if (rem !== 8'd0) begin failures++; $display("FAIL rmr_rem got=%0d want=0", rem); end
        if (err !== 1'b0) begin failures++; $display("FAIL rmr_err got=%b want=0", err); end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rmr_no_result got=%b want=0", seen); end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] x, d;
        for (int i = 0; i < 3; i++) begin
            x = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(1, 255));
            do_op(16'(x) * 16'(d), d, lat);
            checks += 4;
            if (lat !== 8) begin failures++; $display("FAIL rnd%0d_latency got=%0d want=8", i, lat); end
            if (q !== x) begin failures++; $display("FAIL rnd%0d_q x=%0d v=%0d got=%0d want=%0d", i, x, d, q, x); end
            if (rem !== 8'd0) begin failures++; $display("FAIL rnd%0d_rem got=%0d want=0", i, rem); end
            if (err !== 1'b0) begin failures++; $display("FAIL rnd%0d_err got=%b want=0", i, err); end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_max_quotient();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
